// File: rtl/mem_wb_stage_if.sv
// MEM->WB handshake bundle: upstream valid/ready payload, downstream valid/ready
// result, and the forwarding tap used by the hazard unit.
// master = the surrounding pipeline, slave = the stage register itself.
interface mem_wb_stage_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int IMM_W      = 16
);
  // Upstream side (from the data-memory stage)
  logic                  in_valid;
  logic                  in_ready;
  logic [1:0]            in_RegSrc;
  logic                  in_RegWrite;
  logic [DATA_W-1:0]     in_ALUOut;
  logic [DATA_W-1:0]     in_Mem_dataOut;
  logic [REG_ADDR_W-1:0] in_write_reg_dest;
  logic [IMM_W-1:0]      in_immediate;

  // Downstream side (to the register-file write port)
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_RegWrite;
  logic [REG_ADDR_W-1:0] out_write_reg_dest;
  logic [DATA_W-1:0]     out_wb_data;

  // Forwarding tap
  logic                  fwd_valid;

  modport master (
    output in_valid, in_RegSrc, in_RegWrite, in_ALUOut, in_Mem_dataOut,
           in_write_reg_dest, in_immediate, out_ready,
    input  in_ready, out_valid, out_RegWrite, out_write_reg_dest, out_wb_data,
           fwd_valid
  );

  modport slave (
    input  in_valid, in_RegSrc, in_RegWrite, in_ALUOut, in_Mem_dataOut,
           in_write_reg_dest, in_immediate, out_ready,
    output in_ready, out_valid, out_RegWrite, out_write_reg_dest, out_wb_data,
           fwd_valid
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline register with one-entry skid buffer, flush and pre-muxed write-back data.
// Latency: 1 cycle from accept to outputs when the main entry is empty or draining.
// Backpressure: absorbs one extra entry while stalled; in_ready drops only when the skid entry is full.
module mem_wb_stage #(
  parameter int DATA_W         = 32,
  parameter int REG_ADDR_W     = 5,
  parameter int IMM_W          = 16,
  parameter int ZERO_REG_GUARD = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  mem_wb_stage_if.slave bus
);

  localparam int EXT_W = DATA_W - IMM_W;

  // One stored entry: write-back value is already selected at capture time,
  // so WB only needs the final value, the enable and the destination.
  typedef struct packed {
    logic                  reg_write;
    logic [REG_ADDR_W-1:0] dest;
    logic [DATA_W-1:0]     wb_data;
  } entry_t;

  entry_t m_q;      // main entry, drives the outputs
  entry_t s_q;      // skid entry, only occupied while M is full and stalled
  logic   m_valid;
  logic   s_valid;

  entry_t cap;      // incoming entry after source select and zero-reg guard
  logic   accept;
  logic   drain;
  logic   in_ready_w;

  logic [DATA_W-1:0] imm_sext;
  logic [DATA_W-1:0] imm_zext;
  logic [DATA_W-1:0] imm_lui;
  logic              dest_is_zero;

  // The skid entry being full is the only reason to refuse input; reset also
  // holds the upstream off so nothing is accepted during the reset cycle.
  assign in_ready_w = ~s_valid & ~rst;
  assign accept     = bus.in_valid & in_ready_w;
  assign drain      = m_valid & bus.out_ready;

  assign imm_sext     = {{EXT_W{bus.in_immediate[IMM_W-1]}}, bus.in_immediate};
  assign imm_zext     = {{EXT_W{1'b0}}, bus.in_immediate};
  assign imm_lui      = imm_zext << 16;
  assign dest_is_zero = (bus.in_write_reg_dest == '0);

  // Build the captured entry: choose the write-back source and suppress
  // writes to r0 when the guard is enabled.
  always_comb begin
    cap = '0;
    cap.dest = bus.in_write_reg_dest;
    cap.reg_write = bus.in_RegWrite & ~((ZERO_REG_GUARD != 0) & dest_is_zero);
    case (bus.in_RegSrc)
      2'd0:    cap.wb_data = bus.in_ALUOut;
      2'd1:    cap.wb_data = bus.in_Mem_dataOut;
      2'd2:    cap.wb_data = imm_sext;
      default: cap.wb_data = imm_lui;
    endcase
  end

  // Main/skid state update. Priority: reset, flush, refill M, overflow to S.
  // S only ever fills while M is full, so M is never empty with S valid and
  // the pair behaves as a strict two-deep FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      m_q     <= '0;
      s_q     <= '0;
    end else if (flush) begin
      // Payload left stale on purpose; it is masked by the valid bits.
      m_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (!m_valid || drain) begin
      if (s_valid) begin
        // in_ready is low here, so no accept can collide with the S->M move.
        m_q     <= s_q;
        m_valid <= 1'b1;
        s_valid <= 1'b0;
      end else if (accept) begin
        m_q     <= cap;
        m_valid <= 1'b1;
      end else begin
        m_valid <= 1'b0;
      end
    end else if (accept) begin
      s_q     <= cap;
      s_valid <= 1'b1;
    end
  end

  // Outputs come from M only; the write enable is qualified by valid so a
  // stale payload can never trigger a register-file write.
  assign bus.in_ready           = in_ready_w;
  assign bus.out_valid          = m_valid;
  assign bus.out_RegWrite       = m_valid & m_q.reg_write;
  assign bus.out_write_reg_dest = m_q.dest;
  assign bus.out_wb_data        = m_q.wb_data;
  assign bus.fwd_valid          = m_valid & m_q.reg_write & (m_q.dest != '0);

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed vector table, hand-written
// stall/flush/reset sequences, then random traffic against a 2-deep FIFO model.
// Inputs are driven and outputs sampled on the falling edge.
module tb_mem_wb_stage;

  logic clk = 1'b0;
  logic rst;
  logic flush;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_wb_stage_if #(.DATA_W(32), .REG_ADDR_W(5), .IMM_W(16)) bus ();

  mem_wb_stage #(
    .DATA_W(32), .REG_ADDR_W(5), .IMM_W(16), .ZERO_REG_GUARD(1)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus)
  );

  typedef struct {
    logic [1:0]  src;
    logic        rw;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [4:0]  dest;
    logic [15:0] imm;
    logic [31:0] exp_wb;
    logic        exp_rw;
    logic        exp_fwd;
  } vec_t;

  typedef struct {
    logic        rw;
    logic [4:0]  dest;
    logic [31:0] wb;
  } ent_t;

  vec_t vecs[7];
  ent_t q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] src, input logic rw,
                       input logic [31:0] alu, input logic [31:0] mem,
                       input logic [4:0] dest, input logic [15:0] imm);
    bus.in_valid          = v;
    bus.in_RegSrc         = src;
    bus.in_RegWrite       = rw;
    bus.in_ALUOut         = alu;
    bus.in_Mem_dataOut    = mem;
    bus.in_write_reg_dest = dest;
    bus.in_immediate      = imm;
  endtask

  task automatic drive_alu(input logic [31:0] val, input logic [4:0] dest);
    drive(1'b1, 2'd0, 1'b1, val, 32'h0, dest, 16'h0);
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  // advance one full clock, landing on the next falling edge
  task automatic tick();
    @(negedge clk);
  endtask

  // Reference rules for a captured entry, written straight from the source table.
  function automatic ent_t ref_capture(input logic [1:0] src, input logic rw,
                                       input logic [31:0] alu, input logic [31:0] mem,
                                       input logic [4:0] dest, input logic [15:0] imm);
    ent_t e;
    e.dest = dest;
    e.rw   = rw && (dest != 5'd0);
    case (src)
      2'd0:    e.wb = alu;
      2'd1:    e.wb = mem;
      2'd2:    e.wb = 32'($signed(imm));
      default: e.wb = 32'(imm) * 32'h10000;
    endcase
    return e;
  endfunction

  function automatic vec_t mk(input logic [1:0] src, input logic rw, input logic [4:0] dest,
                              input logic [31:0] exp_wb, input logic exp_rw, input logic exp_fwd);
    vec_t v;
    v.src = src; v.rw = rw; v.alu = 32'h11; v.mem = 32'h22; v.dest = dest; v.imm = 16'h8001;
    v.exp_wb = exp_wb; v.exp_rw = exp_rw; v.exp_fwd = exp_fwd;
    return v;
  endfunction

  initial begin
    // source-select sweep, then zero-register guard cases
    vecs[0] = mk(2'd0, 1'b1, 5'd3, 32'h0000_0011, 1'b1, 1'b1);
    vecs[1] = mk(2'd1, 1'b1, 5'd3, 32'h0000_0022, 1'b1, 1'b1);
    vecs[2] = mk(2'd2, 1'b1, 5'd3, 32'hFFFF_8001, 1'b1, 1'b1);
    vecs[3] = mk(2'd3, 1'b1, 5'd3, 32'h8001_0000, 1'b1, 1'b1);
    vecs[4] = mk(2'd0, 1'b1, 5'd0, 32'h0000_0011, 1'b0, 1'b0);
    vecs[5] = mk(2'd0, 1'b1, 5'd7, 32'h0000_0011, 1'b1, 1'b1);
    vecs[6] = mk(2'd1, 1'b0, 5'd7, 32'h0000_0022, 1'b0, 1'b0);

    // ---------------- reset ----------------
    rst = 1'b1; flush = 1'b0; bus.out_ready = 1'b1;
    drive(1'b1, 2'd0, 1'b1, 32'h55, 32'h66, 5'd9, 16'h1234);
    tick(); tick();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_wb_data", bus.out_wb_data, 32'd0);
    chk("rst_dest", 32'(bus.out_write_reg_dest), 32'd0);
    chk("rst_regwrite", 32'(bus.out_RegWrite), 32'd0);
    chk("rst_fwd", 32'(bus.fwd_valid), 32'd0);
    rst = 1'b0; idle();
    tick();
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("post_rst_out_valid", 32'(bus.out_valid), 32'd0);

    // ---------------- vector table (back-to-back, out_ready high) ----------------
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, vecs[i].src, vecs[i].rw, vecs[i].alu, vecs[i].mem, vecs[i].dest, vecs[i].imm);
      tick();
      chk($sformatf("vec%0d_out_valid", i), 32'(bus.out_valid), 32'd1);
      chk($sformatf("vec%0d_wb_data", i), bus.out_wb_data, vecs[i].exp_wb);
      chk($sformatf("vec%0d_dest", i), 32'(bus.out_write_reg_dest), 32'(vecs[i].dest));
      chk($sformatf("vec%0d_regwrite", i), 32'(bus.out_RegWrite), 32'(vecs[i].exp_rw));
      chk($sformatf("vec%0d_fwd", i), 32'(bus.fwd_valid), 32'(vecs[i].exp_fwd));
      chk($sformatf("vec%0d_in_ready", i), 32'(bus.in_ready), 32'd1);
    end
    idle();
    tick();
    chk("table_drained", 32'(bus.out_valid), 32'd0);

    // ---------------- stall / skid: A, B, C ----------------
    bus.out_ready = 1'b0;
    drive_alu(32'hA, 5'd1);
    tick();
    chk("stall_A_valid", 32'(bus.out_valid), 32'd1);
    chk("stall_A_data", bus.out_wb_data, 32'hA);
    chk("stall_A_in_ready", 32'(bus.in_ready), 32'd1);
    drive_alu(32'hB, 5'd2);
    tick();
    chk("stall_B_hold_A", bus.out_wb_data, 32'hA);
    chk("stall_B_in_ready", 32'(bus.in_ready), 32'd0);
    drive_alu(32'hC, 5'd3);
    tick();
    chk("stall_C_hold_A", bus.out_wb_data, 32'hA);
    chk("stall_C_in_ready", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    tick();
    chk("release_B_data", bus.out_wb_data, 32'hB);
    chk("release_B_dest", 32'(bus.out_write_reg_dest), 32'd2);
    chk("release_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    chk("release_C_valid", 32'(bus.out_valid), 32'd1);
    chk("release_C_data", bus.out_wb_data, 32'hC);
    idle();
    tick();
    chk("release_empty", 32'(bus.out_valid), 32'd0);

    // ---------------- flush with M and S full ----------------
    bus.out_ready = 1'b0;
    drive_alu(32'hE1, 5'd4);
    tick();
    drive_alu(32'hE2, 5'd5);
    tick();
    chk("flush_full_in_ready", 32'(bus.in_ready), 32'd0);
    drive_alu(32'hD, 5'd6);
    flush = 1'b1;
    tick();
    flush = 1'b0; idle();
    chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_in_ready", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b1;
    tick();
    chk("flush_D_absent", 32'(bus.out_valid), 32'd0);

    // ---------------- flush with simultaneous accept and drain ----------------
    drive_alu(32'h77, 5'd8);
    tick();
    chk("fad_X_valid", 32'(bus.out_valid), 32'd1);
    drive_alu(32'h88, 5'd9);
    flush = 1'b1;
    #1;
    chk("fad_drain_visible", bus.out_wb_data, 32'h77);
    tick();
    flush = 1'b0; idle();
    chk("fad_empty", 32'(bus.out_valid), 32'd0);
    tick();
    chk("fad_Y_absent", 32'(bus.out_valid), 32'd0);

    // ---------------- reset mid-stall ----------------
    bus.out_ready = 1'b0;
    drive_alu(32'h31, 5'd10);
    tick();
    drive_alu(32'h32, 5'd11);
    tick();
    chk("rstall_in_ready_low", 32'(bus.in_ready), 32'd0);
    rst = 1'b1;
    drive_alu(32'h33, 5'd12);
    tick();
    chk("rstall_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rstall_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rstall_wb_zero", bus.out_wb_data, 32'd0);
    rst = 1'b0; idle(); bus.out_ready = 1'b1;
    tick();
    chk("rstall_after_valid", 32'(bus.out_valid), 32'd0);
    chk("rstall_after_in_ready", 32'(bus.in_ready), 32'd1);

    // ---------------- random traffic vs FIFO model ----------------
    q.delete();
    for (int c = 0; c < 3000; c++) begin
      logic        v, ordy, fl, rw, acc, drn;
      logic [1:0]  src;
      logic [31:0] alu, mem;
      logic [4:0]  dest;
      logic [15:0] imm;

      tick();
      chk("rnd_in_ready", 32'(bus.in_ready), 32'(q.size() < 2));
      chk("rnd_out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
      if (q.size() > 0) begin
        chk("rnd_wb_data", bus.out_wb_data, q[0].wb);
        chk("rnd_dest", 32'(bus.out_write_reg_dest), 32'(q[0].dest));
        chk("rnd_regwrite", 32'(bus.out_RegWrite), 32'(q[0].rw));
        chk("rnd_fwd", 32'(bus.fwd_valid), 32'(q[0].rw && q[0].dest != 5'd0));
      end else begin
        chk("rnd_regwrite_idle", 32'(bus.out_RegWrite), 32'd0);
        chk("rnd_fwd_idle", 32'(bus.fwd_valid), 32'd0);
      end

      v    = ($urandom_range(0, 9) < 7);
      ordy = ($urandom_range(0, 9) < 6);
      fl   = ($urandom_range(0, 99) < 3);
      src  = 2'($urandom_range(0, 3));
      rw   = 1'($urandom_range(0, 1));
      alu  = $urandom;
      mem  = $urandom;
      dest = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      imm  = 16'($urandom);
      drive(v, src, rw, alu, mem, dest, imm);
      bus.out_ready = ordy;
      flush = fl;

      acc = v && (q.size() < 2);
      drn = (q.size() > 0) && ordy;
      if (fl) begin
        q.delete();
      end else begin
        if (drn) void'(q.pop_front());
        if (acc) q.push_back(ref_capture(src, rw, alu, mem, dest, imm));
      end
    end

    idle(); flush = 1'b0;
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
